// File: rtl/simplecpu_loader_pkg.sv
// Shared constants for the simplecpu program loader: register map, bit positions, sequencer states.
package simplecpu_loader_pkg;
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DATA   = 8'h08;
  localparam logic [7:0] OFF_SHADOW = 8'h40;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int ST_BUSY    = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_RUN     = 2;
  localparam int ST_CNT     = 8;

  localparam int ENT_W = 12;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_GAP = 2'd2} state_t;
endpackage

// File: rtl/simplecpu_loader_if.sv
// Wishbone classic slave bus seen by the loader; the master side belongs to the management SoC.
interface simplecpu_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave  (input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  output wbs_ack_o, wbs_dat_o);
  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                  input wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/simplecpu_loader_fifo.sv
// Show-ahead synchronous FIFO holding (addr,data) load entries; a pop while full frees room for a push.
module loader_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/simplecpu_loader.sv
// Wishbone program loader for simplecpu: FIFO of (addr,data) drained into the CPU RAM load port.
// Define LOADER_READBACK_EN to build a 16x8 shadow of loaded bytes readable at 0x40 + 4*i.
module simplecpu_loader
  import simplecpu_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  simplecpu_loader_if.slave   wb,
  output logic                load_ram_o,
  output logic [3:0]          load_addr_o,
  output logic [7:0]          load_data_o,
  output logic                cpu_run_o,
  output logic                irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic             req, hit, wr_ctrl, flush, push, pop, full, empty, run, ovf, ram_nx;
  logic [7:0]       off;
  logic [ENT_W-1:0] head;
  logic [AW:0]      count;
  logic [31:0]      rdata;
  logic [CW-1:0]    cnt, cnt_nx;
  state_t           state, state_nx;
  logic             unused;

  // A held strobe during the ack cycle is not a new access.
  assign req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o;
  assign hit     = wb.wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign off     = wb.wbs_adr_i[7:0];
  assign wr_ctrl = req & wb.wbs_we_i & hit & (off == OFF_CTRL);
  assign flush   = wr_ctrl & wb.wbs_dat_i[CTRL_FLUSH];
  assign push    = req & wb.wbs_we_i & hit & (off == OFF_DATA);
  assign unused  = ^{wb.wbs_sel_i, wb.wbs_dat_i[31:12]};

  loader_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .flush(flush), .push(push), .pop(pop),
    .wdata(wb.wbs_dat_i[ENT_W-1:0]), .rdata(head), .full(full), .empty(empty), .count(count)
  );

`ifdef LOADER_READBACK_EN
  logic [7:0] shadow [16];
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else if (pop && !flush) begin
      shadow[head[11:8]] <= head[7:0];
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_CTRL:   rdata[CTRL_RUN] = run;
        OFF_STATUS: begin
          rdata[ST_BUSY]         = (state != S_IDLE) | ~empty;
          rdata[ST_OVF]          = ovf;
          rdata[ST_RUN]          = cpu_run_o;
          rdata[ST_CNT +: AW+1]  = count;
        end
        default: ;
      endcase
`ifdef LOADER_READBACK_EN
      if (off[7:6] == OFF_SHADOW[7:6] && off[1:0] == 2'b00) rdata[7:0] = shadow[off[5:2]];
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      run          <= 1'b0;
      ovf          <= 1'b0;
      cpu_run_o    <= 1'b0;
    end else begin
      wb.wbs_ack_o <= req;
      wb.wbs_dat_o <= (req && !wb.wbs_we_i) ? rdata : '0;
      if (wr_ctrl) run <= wb.wbs_dat_i[CTRL_RUN];
      if (flush)                     ovf <= 1'b0;
      else if (push && full && !pop) ovf <= 1'b1;
      cpu_run_o <= run & empty & (state == S_IDLE);
    end
  end

  // Sequencer: state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      state      <= S_IDLE;
      cnt        <= '0;
      load_ram_o <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      load_ram_o <= ram_nx;
    end
    if (wb_rst_i) begin
      load_addr_o <= '0;
      load_data_o <= '0;
    end else if (pop && !flush) begin
      load_addr_o <= head[11:8];
      load_data_o <= head[7:0];
    end
  end

  // Sequencer: next state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE, S_GAP: begin
        if (!empty) begin
          state_nx = S_LOAD;
          cnt_nx   = CW'(HOLD_CYCLES - 1);
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_LOAD: begin
        if (cnt == '0) state_nx = S_GAP;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sequencer: outputs.
  always_comb begin
    pop    = 1'b0;
    ram_nx = 1'b0;
    irq_o  = 1'b0;
    case (state)
      S_IDLE: begin
        pop    = ~empty;
        ram_nx = ~empty;
      end
      S_LOAD: ram_nx = cnt != '0;
      S_GAP: begin
        pop    = ~empty;
        ram_nx = ~empty;
        irq_o  = empty;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_simplecpu_loader.sv
// Bench for simplecpu_loader: two instances (HOLD_CYCLES 1 and 3) on one bus, checked every cycle against a queue model.
module tb_simplecpu_loader;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 4;

  logic gclk = 1'b0;
  logic rst  = 1'b1;
  always #5 gclk = ~gclk;

  simplecpu_loader_if bif0();
  simplecpu_loader_if bif1();
  assign bif1.wbs_stb_i = bif0.wbs_stb_i;
  assign bif1.wbs_cyc_i = bif0.wbs_cyc_i;
  assign bif1.wbs_we_i  = bif0.wbs_we_i;
  assign bif1.wbs_sel_i = bif0.wbs_sel_i;
  assign bif1.wbs_adr_i = bif0.wbs_adr_i;
  assign bif1.wbs_dat_i = bif0.wbs_dat_i;

  wire [1:0]      ram_v, run_v, irq_v;
  wire [1:0][3:0] la_v;
  wire [1:0][7:0] ld_v;

  simplecpu_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(1)) dut0 (
    .wb_clk_i(gclk), .wb_rst_i(rst), .wb(bif0), .load_ram_o(ram_v[0]), .load_addr_o(la_v[0]),
    .load_data_o(ld_v[0]), .cpu_run_o(run_v[0]), .irq_o(irq_v[0]));
  simplecpu_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(3)) dut1 (
    .wb_clk_i(gclk), .wb_rst_i(rst), .wb(bif1), .load_ram_o(ram_v[1]), .load_addr_o(la_v[1]),
    .load_data_o(ld_v[1]), .cpu_run_o(run_v[1]), .irq_o(irq_v[1]));

  // Reference: pending entries as a queue, strobe as "cycles left", plus one gap cycle.
  typedef logic [11:0] eq_t[$];
  eq_t         mq [2];
  int          m_left [2];
  bit          m_gap [2], m_run [2], m_ovf [2], m_cpu [2], m_ack [2];
  logic [3:0]  m_la [2];
  logic [7:0]  m_ld [2];
  logic [31:0] m_dat [2];
  logic [7:0]  m_sh [2][16];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit req, hitw, idle, empty, full, flush, push, pop, cpu_n;
      logic [7:0] off;
      logic [31:0] rv;
      logic [11:0] e;
      int h;
      h = (k == 0) ? 1 : 3;
      if (rst) begin
        mq[k].delete();
        m_left[k] = 0; m_gap[k] = 0; m_run[k] = 0; m_ovf[k] = 0; m_cpu[k] = 0;
        m_ack[k] = 0; m_la[k] = 0; m_ld[k] = 0; m_dat[k] = 0;
        for (int j = 0; j < 16; j++) m_sh[k][j] = 0;
        continue;
      end
      req   = bif0.wbs_stb_i && bif0.wbs_cyc_i && !m_ack[k];
      hitw  = bif0.wbs_adr_i[31:8] == BASE[31:8];
      off   = bif0.wbs_adr_i[7:0];
      idle  = (m_left[k] == 0) && !m_gap[k];
      empty = mq[k].size() == 0;
      full  = mq[k].size() == DEPTH;
      flush = req && bif0.wbs_we_i && hitw && off == 8'h00 && bif0.wbs_dat_i[1];
      push  = req && bif0.wbs_we_i && hitw && off == 8'h08;
      rv = 0;
      if (hitw) begin
        if (off == 8'h00) rv[0] = m_run[k];
        else if (off == 8'h04) begin
          rv[0] = !idle || !empty;
          rv[1] = m_ovf[k];
          rv[2] = m_cpu[k];
          rv[12:8] = 5'(mq[k].size());
        end
`ifdef LOADER_READBACK_EN
        else if (off >= 8'h40 && off < 8'h80 && off % 4 == 0) rv[7:0] = m_sh[k][(off - 8'h40) / 4];
`endif
      end
      cpu_n    = m_run[k] && empty && idle;
      m_ack[k] = req;
      m_dat[k] = (req && !bif0.wbs_we_i) ? rv : 32'h0;
      if (req && bif0.wbs_we_i && hitw && off == 8'h00) m_run[k] = bif0.wbs_dat_i[0];
      m_cpu[k] = cpu_n;
      if (flush) begin
        mq[k].delete();
        m_ovf[k] = 0; m_left[k] = 0; m_gap[k] = 0;
      end else begin
        pop = !empty && (idle || m_gap[k]);
        if (pop) begin
          e = mq[k].pop_front();
          m_la[k] = e[11:8]; m_ld[k] = e[7:0];
          m_sh[k][e[11:8]] = e[7:0];
          m_left[k] = h; m_gap[k] = 0;
        end else if (m_left[k] > 0) begin
          m_left[k]--;
          if (m_left[k] == 0) m_gap[k] = 1;
        end else begin
          m_gap[k] = 0;
        end
        if (push) begin
          if (full && !pop) m_ovf[k] = 1;
          else mq[k].push_back(bif0.wbs_dat_i[11:0]);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic a;
      logic [31:0] dv;
      a  = (k == 0) ? bif0.wbs_ack_o : bif1.wbs_ack_o;
      dv = (k == 0) ? bif0.wbs_dat_o : bif1.wbs_dat_o;
      chk($sformatf("ack%0d", k), 32'(a), 32'(m_ack[k]));
      chk($sformatf("dat%0d", k), dv, m_dat[k]);
      chk($sformatf("load_ram%0d", k), 32'(ram_v[k]), 32'(m_left[k] > 0));
      chk($sformatf("load_addr%0d", k), 32'(la_v[k]), 32'(m_la[k]));
      chk($sformatf("load_data%0d", k), 32'(ld_v[k]), 32'(m_ld[k]));
      chk($sformatf("cpu_run%0d", k), 32'(run_v[k]), 32'(m_cpu[k]));
      chk($sformatf("irq%0d", k), 32'(irq_v[k]), 32'(m_gap[k] && mq[k].size() == 0));
    end
  endtask

  task automatic cyc1(bit s, bit c, bit w, logic [31:0] a, logic [31:0] d);
    bif0.wbs_stb_i = s;
    bif0.wbs_cyc_i = c;
    bif0.wbs_we_i  = w;
    bif0.wbs_sel_i = 4'($urandom);
    bif0.wbs_adr_i = a;
    bif0.wbs_dat_i = d;
    @(posedge gclk);
    model_step();
    @(negedge gclk);
    check_all();
  endtask

  task automatic idle(int n);
    repeat (n) cyc1(0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    cyc1(1, 1, 1, a, d);
    cyc1(0, 0, 0, a, d);
  endtask

  task automatic rd(logic [31:0] a, output logic [31:0] v0, output logic [31:0] v1);
    cyc1(1, 1, 0, a, 32'h0);
    v0 = bif0.wbs_dat_o;
    v1 = bif1.wbs_dat_o;
    cyc1(0, 0, 0, a, 32'h0);
  endtask

  initial begin
    logic [31:0] v0, v1, a, d;
    int kind;
    bif0.wbs_stb_i = 0; bif0.wbs_cyc_i = 0; bif0.wbs_we_i = 0;
    bif0.wbs_sel_i = 0; bif0.wbs_adr_i = 0; bif0.wbs_dat_i = 0;
    @(negedge gclk);
    idle(2);
    rst = 1'b0;
    chk("rst_cpu_run", 32'(run_v), 32'h0);
    chk("rst_load_ram", 32'(ram_v), 32'h0);
    rd(BASE + 32'h4, v0, v1);
    chk("rst_status0", v0, 32'h0);
    chk("rst_status1", v1, 32'h0);

    // Single entry: strobe one cycle after ack, irq in the gap cycle.
    cyc1(1, 1, 1, BASE + 32'h8, 32'h0000_0A5C);
    chk("a5c_ack", 32'(bif0.wbs_ack_o), 32'h1);
    chk("a5c_ram_early", 32'(ram_v[0]), 32'h0);
    cyc1(0, 0, 0, 32'h0, 32'h0);
    chk("a5c_ram", 32'(ram_v[0]), 32'h1);
    chk("a5c_addr", 32'(la_v[0]), 32'hA);
    chk("a5c_data", 32'(ld_v[0]), 32'h5C);
    cyc1(0, 0, 0, 32'h0, 32'h0);
    chk("a5c_ram_off", 32'(ram_v[0]), 32'h0);
    chk("a5c_irq", 32'(irq_v[0]), 32'h1);
    idle(6);

    // Back-to-back writes outrun the slow instance and overflow it.
    for (int i = 0; i < 10; i++) wr(BASE + 32'h8, {20'h0, 4'(i), 8'($urandom)});
    rd(BASE + 32'h4, v0, v1);
    chk("ovf_slow", 32'(v1[1]), 32'h1);
    chk("ovf_fast", 32'(v0[1]), 32'h0);
    wr(BASE, 32'h2);
    rd(BASE + 32'h4, v0, v1);
    chk("flush_status0", v0, 32'h0);
    chk("flush_status1", v1, 32'h0);

    // Run control.
    wr(BASE, 32'h1);
    chk("run_rise", 32'(run_v), 32'h3);
    wr(BASE + 32'h8, 32'h0000_0123);
    chk("run_drop", 32'(run_v), 32'h0);
    idle(8);
    chk("run_back", 32'(run_v), 32'h3);

    // Reset in the middle of a 3-cycle strobe.
    wr(BASE + 32'h8, 32'h0000_07E1);
    chk("pre_rst_ram1", 32'(ram_v[1]), 32'h1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_ram1", 32'(ram_v[1]), 32'h0);
    rd(BASE + 32'h4, v0, v1);
    chk("rst_mid_status1", v1, 32'h0);

    // Shadow readback.
    wr(BASE + 32'h8, 32'h0000_037E);
    idle(6);
    rd(BASE + 32'h4C, v0, v1);
`ifdef LOADER_READBACK_EN
    chk("shadow3_0", v0, 32'h7E);
    chk("shadow3_1", v1, 32'h7E);
`else
    chk("shadow3_0", v0, 32'h0);
    chk("shadow3_1", v1, 32'h0);
`endif

    // Random bus traffic, including held strobes, stray cycles and out-of-window hits.
    for (int n = 0; n < 600; n++) begin
      kind = $urandom_range(0, 9);
      d = $urandom;
      case ($urandom_range(0, 7))
        0, 1, 2: a = BASE + 32'h8;
        3:       begin a = BASE; if ($urandom_range(0, 7) != 0) d[1] = 1'b0; end
        4:       a = BASE + 32'h4;
        5:       a = BASE + 32'h40 + 32'(4 * $urandom_range(0, 15));
        6:       a = BASE + 32'($urandom_range(0, 255));
        default: a = BASE + 32'h100 + 32'h8;
      endcase
      if (kind < 3) cyc1(0, 1'($urandom), 1'($urandom), a, d);
      else          cyc1(1, $urandom_range(0, 3) != 0, 1'($urandom), a, d);
    end
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/simplecpu_loader.md
# simplecpu_loader

Wishbone-slave program loader sitting directly upstream of the `simplecpu` core inside the user project. Firmware on the management SoC writes (address, byte) pairs into a small FIFO; a sequencer drains it into the CPU's level-sensitive RAM load port, one entry per strobe. The block also owns the CPU's run/reset line: the CPU is held in reset while any load is pending and released only when firmware sets RUN and loading is idle. This replaces ad-hoc Logic Analyzer driving of the load and reset pins.

## Interface
- `BASE_ADDR`, default `32'h3000_0000`: register window base. Decode matches `wbs_adr_i[31:8] == BASE_ADDR[31:8]`.
- `FIFO_DEPTH`, default 4: number of FIFO entries. Must be a power of two, 2..16.
- `HOLD_CYCLES`, default 1: number of cycles `load_ram_o` stays high per entry. Must be ≥1.

Ports:
- `wb_clk_i`  in  1  the single clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe, cycle and write enable.
- `wbs_sel_i`  in  4  ignored; all accesses are treated as full-word.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  address and write data.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  read data, valid while ack is high, otherwise 0.
- `load_ram_o`  out  1  RAM write strobe to the CPU (level).
- `load_addr_o`  out  4  RAM address to the CPU.
- `load_data_o`  out  8  RAM data to the CPU.
- `cpu_run_o`  out  1  CPU reset line. 1 = run, 0 = held in reset.
- `irq_o`  out  1  one-cycle pulse when loading finishes.

## Operation
Register map (offsets from `BASE_ADDR`):
- `0x00` CTRL, read/write.
  - bit0 RUN: stored.
  - bit1 FLUSH: write-1 pulse, self-clearing, reads as 0.
- `0x04` STATUS, read-only.
  - [0] busy: state ≠ IDLE or FIFO non-empty.
  - [1] overflow: sticky.
  - [2] `cpu_run_o`.
  - [12:8] FIFO count.
- `0x08` DATA, write-only. Pushes `{wbs_dat_i[11:8], wbs_dat_i[7:0]}` as (addr, data). Reads return 0.

Wishbone behaviour:
- Unmapped offsets, or addresses outside the window while `stb & cyc`: acked, reads return 0, writes ignored.
- Write to DATA when the FIFO is full and no pop occurs in the same cycle: entry dropped, overflow set, still acked.
- A simultaneous pop makes room, so the push is accepted.
- FLUSH:
  - Empties the FIFO and clears overflow.
  - Forces the FSM to IDLE.
  - `load_ram_o` goes low on the same edge.

Sequencer FSM:
- IDLE:
  - If FIFO non-empty: pop, latch addr/data onto `load_addr_o`/`load_data_o`, set `load_ram_o=1`, go to LOAD.
- LOAD:
  - Hold for `HOLD_CYCLES` cycles with address and data stable, then `load_ram_o=0` and go to GAP.
- GAP (one cycle, `load_ram_o=0`):
  - If FIFO non-empty: pop and go to LOAD directly.
  - Else go to IDLE and pulse `irq_o`.

Run control:
- `cpu_run_o` is a register loaded each cycle with RUN & FIFO empty & state == IDLE.
- Pushing data while running drops `cpu_run_o`.
- On re-release, the CPU restarts from PC 0.

## Timing
- Reset values:
  - `wbs_ack_o=0`, `wbs_dat_o=0`
  - `load_ram_o=0`, `load_addr_o=0`, `load_data_o=0`
  - `cpu_run_o=0`, `irq_o=0`
  - RUN=0, overflow=0, FIFO empty, state IDLE.
- Reset mid-load drops `load_ram_o` at the reset edge.
- Ack:
  - `stb & cyc` sampled at edge E0 → ack high for exactly one cycle after E0.
  - No new ack is issued while ack is high.
  - Register side effects commit at E0.
- Push at E0 → pop at E1 with `load_ram_o` high from E1 for `HOLD_CYCLES` cycles.
- Throughput: one entry per `HOLD_CYCLES`+1 cycles while the FIFO stays non-empty.
- Last entry's GAP cycle: `irq_o` pulses, state reaches IDLE. If RUN=1, `cpu_run_o` rises one cycle later.

## Configuration
- `LOADER_READBACK_EN` defined:
  - A 16×8 shadow array is updated on every load strobe.
  - Offsets `0x40 + 4*i` (i = 0..15) read back shadow[i] in [7:0].
  - The shadow array resets to 0.
- Undefined: those offsets behave as unmapped (read 0), and no shadow storage is built.

## Structure
- `simplecpu_loader_pkg` holds:
  - register offset constants;
  - CTRL/STATUS bit positions;
  - the FSM state enum (IDLE, LOAD, GAP).
- Sub-module `loader_fifo`: synchronous FIFO, parameterised width (12) and depth, with push/pop/full/empty/count ports and a flush input.

## Test plan
- Reset, then read STATUS → `0x0000_0000`; `cpu_run_o=0`.
- Write DATA `0x0000_0A5C` → `load_ram_o` high 1 cycle with addr=`0xA`, data=`0x5C`, starting 1 cycle after ack; `irq_o` pulses in the GAP cycle.
- With `FIFO_DEPTH=4` and a 5-cycle stall, write 6 entries back-to-back → entries applied in order, at most 1 dropped, STATUS[1]=1; FLUSH → STATUS reads `0x0`.
- Write CTRL=1 with FIFO empty → `cpu_run_o` rises 1 cycle after ack; a DATA write while running → `cpu_run_o` falls 1 cycle after the push and returns after the load completes.
- Assert `wb_rst_i` during LOAD with `HOLD_CYCLES=3` → `load_ram_o=0` and FIFO empty on the next cycle.
- `LOADER_READBACK_EN`: load addr 3 = `0x7E`, then read offset `0x4C` → `0x0000_007E`; without the macro, the same read → 0.
